ps2_arrow_key_decoder: RTL and testbench

// - Decodes the PS/2 scan-code byte stream from the keyboard receiver into level "held" flags.
// - Flags cover the four direction keys; outputs are leftPressed/rightPressed/upPressed/downPressed.
// - These outputs drive the player movement/collision block.
// - Outputs are frame-latched: stable for a whole frame, updated only on startOfFrame.
// - A tap shorter than one frame is never lost.

---
 rtl/ps2_arrow_key_decoder.sv | 181 ++++++++++++++++++
 tb/tb_ps2_arrow_key_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_arrow_key_decoder.sv
// rtl/ps2_arrow_key_decoder.sv - PS/2 scan-code stream to frame-latched arrow-key held flags.
// Optional build macro KEY_LAST_WINS_EN: per-axis last-made key wins when both are active.
module ps2_arrow_key_decoder #(
  parameter logic [7:0] KEY_LEFT   = 8'h6B,
  parameter logic [7:0] KEY_RIGHT  = 8'h74,
  parameter logic [7:0] KEY_UP     = 8'h75,
  parameter logic [7:0] KEY_DOWN   = 8'h72,
  parameter int         PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [7:0] rxByte,
  input  logic       rxValid,
  input  logic       rxError,
  output logic       leftPressed,
  output logic       rightPressed,
  output logic       upPressed,
  output logic       downPressed
);

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_SKIP
  } state_t;

  state_t     r_state, w_state_n;
  logic [7:0] r_cnt, w_cnt_n;
  logic [3:0] r_held, w_held_n;
  logic [3:0] r_seen, w_seen_n;
  logic [3:0] r_out, w_out_n;
  logic [3:0] w_key_oh;
  logic [3:0] w_active;
  logic       w_key_hit;
  logic       w_make;
  logic       w_break;

  // Bit order of all 4-bit key vectors: {down, up, right, left}.
  always_comb begin
    w_key_oh = 4'b0000;
    case (rxByte)
      KEY_LEFT:  w_key_oh = 4'b0001;
      KEY_RIGHT: w_key_oh = 4'b0010;
      KEY_UP:    w_key_oh = 4'b0100;
      KEY_DOWN:  w_key_oh = 4'b1000;
      default:   w_key_oh = 4'b0000;
    endcase
  end

  assign w_key_hit = |w_key_oh;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_make    = 1'b0;
    w_break   = 1'b0;
    if (rxError) begin
      w_state_n = S_IDLE;
      w_cnt_n   = 8'd0;
    end else if (rxValid) begin
      case (r_state)
        S_IDLE: begin
          if (rxByte == PFX_EXT) begin
            w_state_n = S_EXT;
          end else if (rxByte == PFX_BRK) begin
            w_state_n = S_BRK;
          end else if (rxByte == PFX_PAUSE) begin
            w_state_n = S_SKIP;
            w_cnt_n   = 8'(PAUSE_SKIP);
          end else begin
            w_make = w_key_hit;
          end
        end
        S_EXT: begin
          if (rxByte == PFX_EXT) begin
            w_state_n = S_EXT;
          end else if (rxByte == PFX_BRK) begin
            w_state_n = S_BRK;
          end else begin
            w_make    = w_key_hit;
            w_state_n = S_IDLE;
          end
        end
        S_BRK: begin
          w_break   = w_key_hit;
          w_state_n = S_IDLE;
        end
        S_SKIP: begin
          w_cnt_n = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            w_state_n = S_IDLE;
            w_cnt_n   = 8'd0;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_held_n = r_held;
    w_seen_n = r_seen;
    if (w_make) begin
      w_held_n = r_held | w_key_oh;
      w_seen_n = r_seen | w_key_oh;
    end else if (w_break) begin
      w_held_n = r_held & ~w_key_oh;
    end
  end

  // Seen keeps a sub-frame tap visible until the next latch even after its break.
  assign w_active = w_held_n | w_seen_n;

`ifdef KEY_LAST_WINS_EN
  logic r_last_h, w_last_h_n;
  logic r_last_v, w_last_v_n;

  always_comb begin
    w_last_h_n = r_last_h;
    w_last_v_n = r_last_v;
    if (w_make) begin
      if (w_key_oh[0]) w_last_h_n = 1'b0;
      if (w_key_oh[1]) w_last_h_n = 1'b1;
      if (w_key_oh[2]) w_last_v_n = 1'b0;
      if (w_key_oh[3]) w_last_v_n = 1'b1;
    end
  end

  always_comb begin
    w_out_n    = w_active;
    w_out_n[0] = w_active[0] & ~(w_active[1] &  w_last_h_n);
    w_out_n[1] = w_active[1] & ~(w_active[0] & ~w_last_h_n);
    w_out_n[2] = w_active[2] & ~(w_active[3] &  w_last_v_n);
    w_out_n[3] = w_active[3] & ~(w_active[2] & ~w_last_v_n);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_last_h <= 1'b0;
      r_last_v <= 1'b0;
    end else begin
      r_last_h <= w_last_h_n;
      r_last_v <= w_last_v_n;
    end
  end
`else
  assign w_out_n = w_active;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_held  <= 4'b0000;
      r_seen  <= 4'b0000;
      r_out   <= 4'b0000;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_held  <= w_held_n;
      if (startOfFrame) begin
        r_out  <= w_out_n;
        r_seen <= 4'b0000;
      end else begin
        r_seen <= w_seen_n;
      end
    end
  end

  assign leftPressed  = r_out[0];
  assign rightPressed = r_out[1];
  assign upPressed    = r_out[2];
  assign downPressed  = r_out[3];

endmodule

// File: tb/tb_ps2_arrow_key_decoder.sv
// tb/tb_ps2_arrow_key_decoder.sv - directed and randomized check of ps2_arrow_key_decoder against a reference model.
module tb_ps2_arrow_key_decoder;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxError;
  logic       leftPressed;
  logic       rightPressed;
  logic       upPressed;
  logic       downPressed;

  int n_checks;
  int n_errors;

  // Reference model: prefix flags plus per-key held/seen, outputs in {down,up,right,left} order.
  bit       m_after_e0;
  bit       m_after_f0;
  int       m_skip;
  bit [3:0] m_held;
  bit [3:0] m_seen;
  bit [3:0] m_out;
  bit       m_last_h;
  bit       m_last_v;

  ps2_arrow_key_decoder dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .rxByte      (rxByte),
    .rxValid     (rxValid),
    .rxError     (rxError),
    .leftPressed (leftPressed),
    .rightPressed(rightPressed),
    .upPressed   (upPressed),
    .downPressed (downPressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [7:0] b);
    case (b)
      8'h6B:   return 0;
      8'h74:   return 1;
      8'h75:   return 2;
      8'h72:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    m_after_e0 = 0;
    m_after_f0 = 0;
    m_skip     = 0;
    m_held     = '0;
    m_seen     = '0;
    m_out      = '0;
    m_last_h   = 0;
    m_last_v   = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    k = key_of(b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (m_after_f0) begin
      m_after_f0 = 0;
      m_after_e0 = 0;
      if (k >= 0) m_held[k] = 0;
    end else if (b == 8'hE0) begin
      m_after_e0 = 1;
    end else if (b == 8'hF0) begin
      m_after_f0 = 1;
      m_after_e0 = 0;
    end else if (b == 8'hE1 && !m_after_e0) begin
      m_skip = 7;
    end else begin
      m_after_e0 = 0;
      if (k >= 0) begin
        m_held[k] = 1;
        m_seen[k] = 1;
        if (k < 2) m_last_h = (k == 1);
        else       m_last_v = (k == 3);
      end
    end
  endfunction

  function automatic void model_step(input bit sof, input bit v, input logic [7:0] b, input bit err);
    bit [3:0] act;
    if (err) begin
      m_after_e0 = 0;
      m_after_f0 = 0;
      m_skip     = 0;
    end else if (v) begin
      model_byte(b);
    end
    if (sof) begin
      act = m_held | m_seen;
`ifdef KEY_LAST_WINS_EN
      if (act[0] && act[1]) act[m_last_h ? 0 : 1] = 0;
      if (act[2] && act[3]) act[m_last_v ? 2 : 3] = 0;
`endif
      m_out  = act;
      m_seen = '0;
    end
  endfunction

  function automatic logic [3:0] dut_out();
    return {downPressed, upPressed, rightPressed, leftPressed};
  endfunction

  // Called just after a rising edge; drives one clock worth of inputs and checks the result.
  task automatic step(input bit sof, input bit v, input logic [7:0] b, input bit err);
    startOfFrame = sof;
    rxValid      = v;
    rxByte       = b;
    rxError      = err;
    @(posedge clk);
    model_step(sof, v, b, err);
    #1;
    check("model_out", 32'(dut_out()), 32'(m_out));
    startOfFrame = 0;
    rxValid      = 0;
    rxError      = 0;
  endtask

  task automatic send(input logic [7:0] b);
    step(0, 1, b, 0);
  endtask

  task automatic frame();
    step(1, 0, 8'h00, 0);
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] b;
    int sel;
    n_checks = 0;
    n_errors = 0;
    resetN = 0;
    startOfFrame = 0;
    rxByte = 0;
    rxValid = 0;
    rxError = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    resetN = 1;
    check("reset_out", 32'(dut_out()), 32'h0);

    send(8'hE0); send(8'h6B); frame();
    check("e0_make_left", 32'(dut_out()), 32'h1);
    send(8'hE0); send(8'hF0); send(8'h6B); frame();
    check("e0_break_left", 32'(dut_out()), 32'h0);

    send(8'h74); send(8'hF0); send(8'h74); frame();
    check("tap_right", 32'(dut_out()), 32'h2);
    frame();
    check("tap_right_end", 32'(dut_out()), 32'h0);

    step(1, 1, 8'h75, 0);
    check("sof_same_clk_up", 32'(dut_out()), 32'h4);
    send(8'hF0); send(8'h75); frame();
    check("up_release", 32'(dut_out()), 32'h0);

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    foreach (pause_seq[i]) send(pause_seq[i]);
    send(8'h72); frame();
    check("pause_then_down", 32'(dut_out()), 32'h8);
    send(8'hF0); send(8'h72); frame();
    check("down_release", 32'(dut_out()), 32'h0);

    step(0, 1, 8'hF0, 1);
    send(8'h6B); frame();
    check("err_f0_make", 32'(dut_out()), 32'h1);
    send(8'hF0); send(8'h6B); frame();

    send(8'h6B); send(8'h74); frame();
`ifdef KEY_LAST_WINS_EN
    check("both_horiz", 32'(dut_out()), 32'h2);
`else
    check("both_horiz", 32'(dut_out()), 32'h3);
`endif
    send(8'hF0); send(8'h74); frame();
    check("right_released", 32'(dut_out()), 32'h1);
    send(8'hF0); send(8'h6B); frame();
    check("all_released", 32'(dut_out()), 32'h0);

    send(8'h75); frame();
    check("pre_reset_up", 32'(dut_out()), 32'h4);
    #2;
    resetN = 0;
    model_reset();
    #1;
    check("async_reset", 32'(dut_out()), 32'h0);
    @(posedge clk);
    #1;
    resetN = 1;
    frame();
    check("first_frame_after_reset", 32'(dut_out()), 32'h0);

    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 8'h6B;
        1: b = 8'h74;
        2: b = 8'h75;
        3: b = 8'h72;
        4: b = 8'hE0;
        5: b = 8'hF0;
        6: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hF0;
        7: b = 8'hF0;
        8: b = 8'($urandom);
        default: b = 8'h6B + 8'($urandom_range(0, 1) * 9);
      endcase
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, b, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
